// File: rtl/avg_filter_pkg.sv
// Shared types and helpers for the whole-frame averaging filter.
// Imported by the frame controller and its counter.
package avg_filter_pkg;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DRAIN
  } ctrl_state_t;

  // Filter register stages: leaf stage plus adder-tree levels.
  function automatic int latency(input int rk, input int ck);
    return $clog2(rk * ck) + 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row-major raster position counter with wrap and last flag.
// Used for both frame load and filtered-frame drain.
module raster_counter #(
  parameter int R_I = 16,
  parameter int C_I = 16,
  parameter int RW  = (R_I > 1) ? $clog2(R_I) : 1,
  parameter int CW  = (C_I > 1) ? $clog2(C_I) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == CW'(C_I - 1));
  assign row_end = (row == RW'(R_I - 1));
  assign last    = col_end && row_end;

  // Advance col, wrap into row, wrap whole frame to origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/avg_filter_frame_ctrl.sv
// Frame sequencer around the averaging filter: load a raster
// frame, enable the filter for its latency, stream result out.
module avg_filter_frame_ctrl
  import avg_filter_pkg::*;
#(
  parameter int R_I = 16,
  parameter int C_I = 16,
  parameter int W_I = 8,
  parameter int R_K = 3,
  parameter int C_K = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [W_I-1:0]                     s_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [W_I-1:0]                     m_data,
  output logic                               m_last,
  output logic                               filt_cen,
  output logic [R_I-1:0][C_I-1:0][W_I-1:0]   filt_img,
  input  logic [R_I-1:0][C_I-1:0][W_I-1:0]   filt_res,
  output logic                               busy,
  output logic                               frame_done
);

  localparam int LAT = latency(R_K, C_K);
  localparam int RCW = $clog2(LAT + 1);
  localparam int RW  = (R_I > 1) ? $clog2(R_I) : 1;
  localparam int CW  = (C_I > 1) ? $clog2(C_I) : 1;

  ctrl_state_t state, state_nx;

  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic           last;
  logic           cnt_en;
  logic [RCW-1:0] run_cnt;
  logic           in_load;
  logic           in_drain;

  logic [R_I-1:0][C_I-1:0][W_I-1:0] frame;

  assign in_load  = (state == LOAD);
  assign in_drain = (state == DRAIN);
  assign cnt_en   = (in_load && s_valid && !rst)
                  || (in_drain && m_ready);

  raster_counter #(
    .R_I (R_I),
    .C_I (C_I),
    .RW  (RW),
    .CW  (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .row  (row),
    .col  (col),
    .last (last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  // Next state and handshake/enable outputs.
  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data   = '0;
    filt_cen = 1'b0;
    busy     = 1'b0;
    unique case (state)
      LOAD: begin
        s_ready = !rst;
        if (s_valid && last) state_nx = RUN;
      end
      RUN: begin
        filt_cen = 1'b1;
        busy     = 1'b1;
        if (run_cnt == RCW'(LAT - 1)) state_nx = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_data  = filt_res[row][col];
        m_last  = last;
        if (m_ready && last) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // Count filter-enable cycles while in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                run_cnt <= '0;
    else if (state == RUN)  run_cnt <= run_cnt + 1'b1;
    else                    run_cnt <= '0;
  end

  // Capture accepted pixels into the frame register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     frame <= '0;
    else if (in_load && s_valid) frame[row][col] <= s_data;
  end

  // One-cycle pulse after the final output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= in_drain && m_ready && last;
  end

  assign filt_img = frame;

endmodule

// File: tb/tb_avg_filter_frame_ctrl.sv
// Directed bench for the frame controller with a behavioural
// 3x3 zero-padded averaging filter attached.
module tb_avg_filter_frame_ctrl;
  import avg_filter_pkg::*;

  localparam int R = 4;
  localparam int C = 4;
  localparam int W = 8;
  localparam int L = latency(3, 3);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [W-1:0] s_data = '0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic m_last;
  logic filt_cen;
  logic [R-1:0][C-1:0][W-1:0] filt_img;
  logic [R-1:0][C-1:0][W-1:0] filt_res;
  logic busy;
  logic frame_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avg_filter_frame_ctrl #(
    .R_I (R), .C_I (C), .W_I (W), .R_K (3), .C_K (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .filt_cen   (filt_cen),
    .filt_img   (filt_img),
    .filt_res   (filt_res),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Behavioural filter: L enabled stages, result held when cen=0.
  logic [R-1:0][C-1:0][W-1:0] pipe [L];

  function automatic logic [R-1:0][C-1:0][W-1:0]
    avg3(input logic [R-1:0][C-1:0][W-1:0] img);
    logic [R-1:0][C-1:0][W-1:0] o;
    int s;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < R && c + dc >= 0 && c + dc < C)
              s += int'(img[r+dr][c+dc]);
        o[r][c] = W'(s / 9);
      end
    return o;
  endfunction

  initial for (int i = 0; i < L; i++) pipe[i] = '0;

  always @(posedge clk) begin
    if (filt_cen) begin
      pipe[0] <= avg3(filt_img);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign filt_res = pipe[L-1];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input logic [W-1:0] px [16],
                            input bit bubbles);
    int idx = 0;
    int g = 0;
    int cen = 0;
    bit tog = 1'b0;
    while (idx < 16 && g < 80) begin
      @(negedge clk);
      g++;
      if (bubbles && tog) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = px[idx];
      end
      tog = ~tog;
      if (idx == 0) chk("s_ready_load", s_ready, 1);
      if (s_valid && s_ready) idx++;
    end
    chk("load_count", idx, 16);
    @(negedge clk);
    s_valid = 1'b0;
    chk("busy_run", busy, 1);
    chk("s_ready_run", s_ready, 0);
    g = 0;
    while (!m_valid && g < 20) begin
      if (filt_cen) cen++;
      @(negedge clk);
      g++;
    end
    chk("cen_cycles", cen, L);
  endtask

  task automatic drain(input logic [W-1:0] e [16],
                       input int bp_at, input int stop_at);
    int k = 0;
    int hold = 0;
    int g = 0;
    while (k < stop_at && g < 80) begin
      @(negedge clk);
      g++;
      if (k == bp_at && hold < 3) begin
        m_ready = 1'b0;
        hold++;
        chk("bp_valid", m_valid, 1);
      end else begin
        m_ready = 1'b1;
      end
      if (m_valid) begin
        chk($sformatf("m_data[%0d]", k), m_data, e[k]);
        chk($sformatf("m_last[%0d]", k), m_last, (k == 15));
        if (m_ready) k++;
      end
    end
    chk("drain_count", k, stop_at);
    if (stop_at == 16) begin
      @(negedge clk);
      m_ready = 1'b0;
      chk("frame_done_hi", frame_done, 1);
      chk("busy_idle", busy, 0);
      chk("m_valid_idle", m_valid, 0);
      chk("s_ready_idle", s_ready, 1);
      @(negedge clk);
      chk("frame_done_lo", frame_done, 0);
    end else begin
      @(negedge clk);
      m_ready = 1'b0;
    end
  endtask

  logic [W-1:0] f90  [16];
  logic [W-1:0] f180 [16];
  logic [W-1:0] fimp [16];
  logic [W-1:0] e90  [16] = '{40, 60, 60, 40, 60, 90, 90, 60,
                              60, 90, 90, 60, 40, 60, 60, 40};
  logic [W-1:0] e180 [16] = '{80, 120, 120, 80, 120, 180, 180, 120,
                              120, 180, 180, 120, 80, 120, 120, 80};
  logic [W-1:0] eimp [16] = '{28, 28, 28, 0, 28, 28, 28, 0,
                              28, 28, 28, 0, 0, 0, 0, 0};

  initial begin
    for (int i = 0; i < 16; i++) begin
      f90[i]  = 8'd90;
      f180[i] = 8'd180;
      fimp[i] = (i == 5) ? 8'd255 : 8'd0;
    end

    // Reset: initial release, then async pulse mid-cycle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_cen", filt_cen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", s_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Uniform frame.
    load_frame(f90, 1'b0);
    drain(e90, -1, 16);

    // Impulse frame.
    load_frame(fimp, 1'b0);
    drain(eimp, -1, 16);

    // Input bubbles.
    load_frame(f90, 1'b1);
    drain(e90, -1, 16);

    // Output backpressure at index 5.
    load_frame(f90, 1'b0);
    drain(e90, 5, 16);

    // Reset during drain after 7 outputs.
    load_frame(f90, 1'b0);
    drain(e90, -1, 7);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_load", s_ready, 1);
    load_frame(f180, 1'b0);
    drain(e180, -1, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avg_filter_frame_ctrl.md
Name: avg_filter_frame_ctrl

Overview:
Sequencer that wraps the whole-frame averaging filter datapath. It collects a raster pixel stream into a frame register and drives it onto the filter's image bus. It then pulses the filter's clock enable for exactly the pipeline latency and streams the filtered frame back out in raster order over a valid/ready interface. It sits between the camera/SDRAM pixel source and the VGA/output path.

Parameters:
R_I, 16, frame rows (padded image height)
C_I, 16, frame columns
W_I, 8, pixel width in bits
R_K, 3, kernel rows (must match filter instance)
C_K, 3, kernel columns (must match filter instance)
LAT, derived localparam = $clog2(R_K*C_K)+1, filter register stages (leaf stage + adder-tree levels)
N_PIX, derived localparam = R_I*C_I

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
s_valid  in  1  input pixel valid
s_ready  out  1  controller accepts input pixel
s_data  in  W_I  input pixel, row-major raster order
m_valid  out  1  filtered pixel valid
m_ready  in  1  downstream accepts filtered pixel
m_data  out  W_I  filtered pixel
m_last  out  1  high with the final pixel (N_PIX-1) of a frame
filt_cen  out  1  clock enable to filter
filt_img  out  [R_I-1:0][C_I-1:0][W_I-1:0]  frame register driven to filter input
filt_res  in  [R_I-1:0][C_I-1:0][W_I-1:0]  filter output image
busy  out  1  high in RUN or DRAIN
frame_done  out  1  one-cycle pulse after last output handshake

Behaviour:
- Reset (async, active-high, any state): state=LOAD, row/col counters=0, frame register cleared to 0, run counter=0. filt_cen=0, m_valid=0, m_last=0, busy=0, frame_done=0. s_ready=1 after rst deasserts.
- Single raster counter (row, col). Increments col; at col==C_I-1 it wraps to 0 and increments row. At (R_I-1, C_I-1) it wraps to (0,0).
- LOAD: s_ready=1, m_valid=0, filt_cen=0.
  - Each s_valid&&s_ready cycle writes s_data into frame[row][col] and advances the counter.
  - Cycles with s_valid=0 do not advance the counter.
  - The handshake at index N_PIX-1 moves the state to RUN and sets run counter=0.
- RUN: s_ready=0, m_valid=0, filt_cen=1 for exactly LAT consecutive cycles.
  - The run counter increments each cycle. At run counter==LAT-1 the state moves to DRAIN.
  - filt_img is stable for the whole RUN.
- DRAIN: filt_cen=0, so the filter holds its result. m_valid=1 and m_data=filt_res[row][col] (combinational index of the held bus, no extra latency). m_last=1 iff the counter is at N_PIX-1.
  - m_valid&&m_ready advances the counter.
  - While m_valid&&!m_ready, m_data and m_last hold stable.
  - The handshake with m_last moves the state to LOAD. frame_done is registered high for the next cycle only.
- Inputs are ignored outside LOAD. s_ready=0 means upstream must hold its data.
- Frame register is not cleared between frames; each frame fully overwrites it.
- Minimum frame period: N_PIX (LOAD) + LAT (RUN) + N_PIX (DRAIN) cycles.
- busy = (state==RUN)||(state==DRAIN).
- No arithmetic in the controller; all division and width handling stays in the filter.

Decomposition:
- Shared package avg_filter_pkg holds:
  - state enum ctrl_state_t {LOAD, RUN, DRAIN}
  - function latency(R_K, C_K) returning $clog2(R_K*C_K)+1, reused by the filter and the bench
- One sub-module: raster_counter (row/col counter with enable, wrap, and last flag), parameterised by R_I and C_I.
- The filter is instantiated by the parent next to this block, not inside it.

Test Plan:
All scenarios use R_I=C_I=4, R_K=C_K=3 (LAT=5) with the real averaging_filter attached.
1. Reset: rst pulse mid-clock (async) -> all outputs 0 immediately. After release, s_ready=1, busy=0.
2. Uniform frame:
   - Stimulus: 16 pixels of 90, back-to-back.
   - filt_cen high exactly 5 cycles.
   - Outputs in order: 40,60,60,40, 60,90,90,60, 60,90,90,60, 40,60,60,40.
   - m_last only on the 16th output; frame_done pulses once the cycle after.
3. Impulse: 255 at (1,1), zeros elsewhere -> outputs 28 at rows 0-2 × cols 0-2, 0 at all other pixels.
4. Input bubbles: s_valid toggled 1,0,1,0 over the frame -> counter advances only on handshakes; result identical to scenario 2.
5. Backpressure: m_ready held 0 for 3 cycles at output 5 -> m_data=90 and m_valid stay stable; no pixel is skipped or duplicated; total output count is 16.
6. Reset mid-DRAIN after 7 outputs -> m_valid=0 and state=LOAD. The next full frame of all-180 produces 80,120,120,80 in the first row.
